// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared constants and state encoding for the divide issue controller
package div_issue_ctrl_pkg;

  localparam int DIV_DW = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - start/busover handshake and operand/result bus to the radix-4 divider
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic [DIV_DW-1:0] div_a;
  logic [DIV_DW-1:0] div_b;
  logic              div_start;
  logic              div_busover;
  logic [DIV_DW-1:0] div_q;
  logic [DIV_DW-1:0] div_r;
  logic              div_done;

  modport master (
    output div_a, div_b, div_start, div_busover,
    input  div_q, div_r, div_done
  );

  modport slave (
    input  div_a, div_b, div_start, div_busover,
    output div_q, div_r, div_done
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage DIV/DIVU issue, stall and HI/LO writeback around an unsigned divider
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_req,
  input  logic              ex_div_signed,
  input  logic [DW-1:0]     ex_op_a,
  input  logic [DW-1:0]     ex_op_b,
  input  logic              flush,
  output logic              stall_req,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DW-1:0]     hi_wdata,
  output logic [DW-1:0]     lo_wdata,
  div_issue_ctrl_if.master  div
);

  div_state_t    state;
  logic          neg_q;
  logic          neg_r;
  logic          drain_first;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    mag_a = (ex_div_signed && ex_op_a[DW-1]) ? (~ex_op_a + 1'b1) : ex_op_a;
    mag_b = (ex_div_signed && ex_op_b[DW-1]) ? (~ex_op_b + 1'b1) : ex_op_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      div.div_a   <= '0;
      div.div_b   <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      drain_first <= 1'b0;
      hi_wdata    <= '0;
      lo_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_div_req && !flush) begin
            div.div_a <= mag_a;
            div.div_b <= mag_b;
            neg_q     <= ex_div_signed & (ex_op_a[DW-1] ^ ex_op_b[DW-1]);
            neg_r     <= ex_div_signed & ex_op_a[DW-1];
            state     <= ISSUE;
          end
        end
        // divider still shows done from its parked state here, so it is not looked at
        ISSUE: begin
          drain_first <= 1'b1;
          state       <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (flush) begin
            drain_first <= 1'b1;
            state       <= DRAIN;
          end else if (div.div_done) begin
            lo_wdata <= neg_q ? (~div.div_q + 1'b1) : div.div_q;
            hi_wdata <= neg_r ? (~div.div_r + 1'b1) : div.div_r;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          drain_first <= 1'b0;
          if (!drain_first && div.div_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // busover stays low until we leave WAIT/DRAIN so the divider parks instead of restarting
  assign div.div_start   = (state == ISSUE) || (state == WAIT) || (state == DRAIN);
  assign div.div_busover = !((state == WAIT) || (state == DRAIN));
  assign stall_req       = ex_div_req && (state != DONE);
  assign hi_we           = (state == DONE);
  assign lo_we           = (state == DONE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed vector bench for div_issue_ctrl with a behavioural radix-4 divider
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_div_req;
  logic        ex_div_signed;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        flush;
  logic        stall_req;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int checks = 0;
  int errors = 0;

  div_issue_ctrl_if dif ();

  div_issue_ctrl #(.DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_div_req    (ex_div_req),
    .ex_div_signed (ex_div_signed),
    .ex_op_a       (ex_op_a),
    .ex_op_b       (ex_op_b),
    .flush         (flush),
    .stall_req     (stall_req),
    .hi_we         (hi_we),
    .lo_we         (lo_we),
    .hi_wdata      (hi_wdata),
    .lo_wdata      (lo_wdata),
    .div           (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider: load at count 0, iterate to 17, hold at 17 while busover=0, freeze when start=0
  logic [4:0]  cnt;
  logic [31:0] mq;
  logic [31:0] mr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 5'd0;
      mq  <= 32'd0;
      mr  <= 32'd0;
    end else if (dif.div_start) begin
      if (cnt == 5'd17) begin
        if (dif.div_busover) cnt <= 5'd0;
      end else if (cnt == 5'd0) begin
        cnt <= 5'd1;
        mq  <= (dif.div_b == 32'd0) ? 32'hFFFF_FFFF : dif.div_a / dif.div_b;
        mr  <= (dif.div_b == 32'd0) ? dif.div_a : dif.div_a % dif.div_b;
      end else begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign dif.div_q    = mq;
  assign dif.div_r    = mr;
  assign dif.div_done = (cnt == 5'd17);

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          flush_at;
    bit          wr;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int          wr_cnt = 0;
    int          wr_cyc = -1;
    int          st_cnt = 0;
    int          st_first = -1;
    int          end_cyc = -1;
    logic [31:0] lo_s = '0;
    logic [31:0] hi_s = '0;
    logic        stall_s = 1'b1;
    logic        bo_s = 1'b0;
    logic        lowe_s = 1'b0;
    logic        stall0 = 1'b0;
    bit          fin = 0;
    bit          killed = 0;
    bit          wr_now;
    ex_div_req    = 1'b1;
    ex_div_signed = v.sgn;
    ex_op_a       = v.a;
    ex_op_b       = v.b;
    for (int n = 0; n < 50 && !fin; n++) begin
      flush = (n == v.flush_at);
      @(negedge clk);
      if (n == 0) stall0 = stall_req;
      if (dif.div_start) begin
        st_cnt++;
        if (st_first < 0) st_first = n;
      end
      wr_now = hi_we;
      if (hi_we) begin
        wr_cnt++;
        wr_cyc  = n;
        lo_s    = lo_wdata;
        hi_s    = hi_wdata;
        stall_s = stall_req;
        bo_s    = dif.div_busover;
        lowe_s  = lo_we;
      end
      if (killed && !dif.div_start) begin
        fin     = 1;
        end_cyc = n;
      end
      if (n == v.flush_at && !hi_we) killed = 1;
      @(posedge clk);
      #1;
      if (wr_now) begin
        fin     = 1;
        end_cyc = n;
      end
      if (fin || killed) begin
        ex_div_req = 1'b0;
      end
    end
    flush      = 1'b0;
    ex_div_req = 1'b0;
    chk({v.name, " finished"}, 32'(fin), 32'd1);
    chk({v.name, " stall at request"}, 32'(stall0), 32'd1);
    if (v.wr) begin
      chk({v.name, " write count"}, 32'(wr_cnt), 32'd1);
      chk({v.name, " write cycle"}, 32'(wr_cyc), 32'(v.lat));
      chk({v.name, " lo"}, lo_s, v.lo);
      chk({v.name, " hi"}, hi_s, v.hi);
      chk({v.name, " lo_we with hi_we"}, 32'(lowe_s), 32'd1);
      chk({v.name, " stall at write"}, 32'(stall_s), 32'd0);
      chk({v.name, " busover at write"}, 32'(bo_s), 32'd1);
      chk({v.name, " start first cycle"}, 32'(st_first), 32'd1);
      chk({v.name, " start cycles"}, 32'(st_cnt), 32'(v.lat - 1));
    end else begin
      chk({v.name, " write count"}, 32'(wr_cnt), 32'd0);
      chk({v.name, " drain end cycle"}, 32'(end_cyc), 32'(v.lat));
    end
  endtask

  initial begin
    vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,       32'd7,         -1, 1'b1, 32'd14,        32'd2,         19};
    vecs[1]  = '{"div_m100_7",     1'b1, 32'hFFFF_FF9C, 32'd7,         -1, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 20};
    vecs[2]  = '{"div_100_m7",     1'b1, 32'd100,       32'hFFFF_FFF9, -1, 1'b1, 32'hFFFF_FFF2, 32'd2,         20};
    vecs[3]  = '{"div_min_m1",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h8000_0000, 32'd0,         20};
    vecs[4]  = '{"divu_max_1",     1'b0, 32'hFFFF_FFFF, 32'd1,         -1, 1'b1, 32'hFFFF_FFFF, 32'd0,         20};
    vecs[5]  = '{"divu_5_0",       1'b0, 32'd5,         32'd0,         -1, 1'b1, 32'hFFFF_FFFF, 32'd5,         20};
    vecs[6]  = '{"div_m7_0",       1'b1, 32'hFFFF_FFF9, 32'd0,         -1, 1'b1, 32'd1,         32'hFFFF_FFF9, 20};
    vecs[7]  = '{"flush_wait",     1'b0, 32'd1000,      32'd3,          8, 1'b0, 32'd0,         32'd0,         20};
    vecs[8]  = '{"divu_9_2",       1'b0, 32'd9,         32'd2,         -1, 1'b1, 32'd4,         32'd1,         20};
    vecs[9]  = '{"flush_done",     1'b0, 32'd50,        32'd5,         20, 1'b1, 32'd10,        32'd0,         20};
    vecs[10] = '{"flush_issue",    1'b0, 32'd8,         32'd2,          1, 1'b0, 32'd0,         32'd0,         20};
    vecs[11] = '{"divu_21_4",      1'b0, 32'd21,        32'd4,         -1, 1'b1, 32'd5,         32'd1,         20};

    rst           = 1'b1;
    ex_div_req    = 1'b0;
    ex_div_signed = 1'b0;
    ex_op_a       = 32'd0;
    ex_op_b       = 32'd0;
    flush         = 1'b0;
    #2 rst = 1'b0;
    #2;
    chk("reset stall_req", 32'(stall_req), 32'd0);
    chk("reset hi_we", 32'(hi_we), 32'd0);
    chk("reset lo_we", 32'(lo_we), 32'd0);
    chk("reset hi_wdata", hi_wdata, 32'd0);
    chk("reset lo_wdata", lo_wdata, 32'd0);
    chk("reset div_a", dif.div_a, 32'd0);
    chk("reset div_b", dif.div_b, 32'd0);
    chk("reset div_start", 32'(dif.div_start), 32'd0);
    chk("reset div_busover", 32'(dif.div_busover), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i]);
    end

    // a request accompanied by flush in IDLE must not be accepted
    ex_div_req = 1'b1;
    ex_op_a    = 32'd40;
    ex_op_b    = 32'd4;
    flush      = 1'b1;
    @(negedge clk);
    chk("idle flush stall_req", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1;
    ex_div_req = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    chk("idle flush not issued", 32'(dif.div_start), 32'd0);
    chk("idle flush no write", 32'(hi_we), 32'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("quiet busover", 32'(dif.div_busover), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage initiator for the iterative radix-4 unsigned divider; owns the divider's start/busover handshake.
- Accepts MIPS DIV/DIVU, converts signed operands to magnitudes, drives the divider and stalls the pipeline while it runs.
- Sign-corrects Q/R and writes LO/HI in one cycle.
- A flush arriving mid-operation is drained safely: the divider freezes its counter if start drops early.

Parameters:
- DW, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ex_div_req  in  1  DIV/DIVU valid in EX; held by the pipeline while stall_req=1
- ex_div_signed  in  1  1=DIV, 0=DIVU; sampled with ex_div_req in IDLE
- ex_op_a  in  32  dividend (rs)
- ex_op_b  in  32  divisor (rt)
- flush  in  1  kill the in-flight instruction; its result is discarded
- stall_req  out  1  hold the pipeline
- hi_we, lo_we  out  1 each  HI/LO write strobes, always pulsed together
- hi_wdata, lo_wdata  out  32 each  remainder and quotient, sign-corrected
- div_a, div_b  out  32 each  divider operands, unsigned magnitudes
- div_start  out  1  divider start/hold
- div_busover  out  1  result consumed / release to divider
- div_q, div_r  in  32 each  divider quotient and remainder
- div_done  in  1  divider operation-over flag

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset (rst=0, asynchronous): state=IDLE; div_a, div_b, sign flags, hi/lo_wdata = 0; all strobes = 0.
- IDLE: when ex_div_req & ~flush:
  - div_a <= |a| if signed, else a; div_b likewise.
  - Latch neg_q = signed & (a[31]^b[31]) and neg_r = signed & a[31].
  - Go to ISSUE.
- ISSUE: lasts exactly 1 cycle, then WAIT. div_done is ignored here, because the divider reports done=1 while idle.
- WAIT: stays until div_done=1. On div_done, capture the result:
  - lo_wdata <= neg_q ? -div_q : div_q
  - hi_wdata <= neg_r ? -div_r : div_r
  - Then go to DONE.
- DONE: lasts 1 cycle.
  - hi_we = lo_we = 1 and stall_req = 0, so the instruction advances.
  - Next state is IDLE. ex_div_req is not re-sampled in this cycle.
- Divider handshake outputs are pure decode of state:
  - div_start = (ISSUE | WAIT | DRAIN)
  - div_busover = ~(WAIT | DRAIN)
  - This guarantees the divider holds its finished result at count 17 until the controller leaves WAIT, and never auto-restarts.
- stall_req = ex_div_req & (state != DONE).
  - In DRAIN: stall_req = ex_div_req, since a new DIV must wait.
- Flush in ISSUE or WAIT: go to DRAIN. No HI/LO write; flush in the same cycle as div_done also goes to DRAIN.
- DRAIN: keeps start=1, busover=0 until div_done=1 (checked from the 2nd DRAIN cycle onward), then goes to IDLE. The result is discarded.
- Flush in IDLE: the request is not accepted. Flush in DONE: the write still occurs, because the instruction has already completed.
- Latency: request seen in IDLE at cycle 0.
  - Divider fresh from reset: done at cycle 18, DONE (write) at cycle 19.
  - Divider parked after a previous op: one extra reload cycle, so DONE at cycle 20.
- Widths: negation is 32-bit two's complement. |0x80000000| = 0x80000000 as unsigned.
- Divide by zero: no trap. Runs normally and writes whatever the divider returns, sign-corrected. Must complete with the same latency and never hang.

Decomposition:
- Shared package: state encoding constants (IDLE/ISSUE/WAIT/DONE/DRAIN) and DW.
- No sub-module needed; the magnitude/negate logic is inline.
- The bench instantiates this block together with the existing divider.

Test Plan:
- DIVU 100/7 from reset → div_start high cycles 1–18; at cycle 19 lo_we=hi_we=1, LO=14, HI=2, stall_req=0.
- DIV -100/7 then DIV 100/-7 back-to-back → LO=0xFFFFFFF2, HI=0xFFFFFFFE, then LO=0xFFFFFFF2, HI=2. The second write lands at cycle 20 after its request.
- DIV 0x80000000/-1 → LO=0x80000000, HI=0; DIVU 0xFFFFFFFF/1 → LO=0xFFFFFFFF, HI=0.
- Flush at cycle 8 of an op → no hi_we/lo_we; DRAIN until div_done. A following DIVU 9/2 gives LO=4, HI=1, which checks that the divider was not left mid-count.
- Idle divider (done=1, count parked) plus a new request → no write at ISSUE; exactly one write per request.
- Divide by zero → completes at the normal latency, with exactly one write pulse.
